frame_write_packer: RTL and testbench

//  Parametrised camera-to-SDRAM write path: drains the camera pixel FIFO, packs pixels into

---
 rtl/frame_write_packer.sv | 219 +++++++++++++++++++++
 tb/tb_frame_write_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_packer.sv
// rtl/frame_write_packer.sv - packs camera FIFO pixels into fixed-length SDRAM write bursts
// Optional feature macro: FRAME_WRITE_PACKER_MASK_EN (byte-mask padded lanes of partial bursts).
module frame_write_packer #(
  parameter int PIXEL_WIDTH    = 16,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 21,
  parameter int BURST_BEATS    = 8,
  parameter int GAP_CYCLES     = 11,
  parameter int FRAME_PIXELS   = 307200,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE_0 = 21'h096040,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE_1 = 21'h12C080
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init_done,
  input  logic                        fifo_empty,
  input  logic [PIXEL_WIDTH:0]        fifo_data,
  output logic                        fifo_rd_en,
  output logic                        cmd,
  output logic                        cmd_en,
  output logic [ADDR_WIDTH-1:0]       addr,
  output logic [MEM_DATA_WIDTH-1:0]   wr_data,
  output logic [MEM_DATA_WIDTH/8-1:0] data_mask,
  output logic                        active_buffer,
  output logic                        frame_done,
  output logic                        error
);
  localparam int PPW = MEM_DATA_WIDTH / PIXEL_WIDTH;
  localparam int BP  = BURST_BEATS * PPW;
  localparam int FW  = $clog2(BP + 1);
  localparam int CW  = $clog2(FRAME_PIXELS + 1);
  localparam int BW  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int MW  = MEM_DATA_WIDTH / 8;

  typedef enum logic [2:0] {S_WAIT_INIT, S_HUNT, S_FILL, S_BURST, S_GAP} state_t;

  state_t                  state_q, state_d;
  logic                    rd_q, rd_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic [CW-1:0]           pcnt_q, pcnt_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [PIXEL_WIDTH-1:0]  pix_q [BP];
  logic [PIXEL_WIDTH-1:0]  pix_d [BP];
  logic                    sof_pend_q, sof_pend_d;
  logic [PIXEL_WIDTH-1:0]  sof_pix_q, sof_pix_d;
  logic                    done_pend_q, done_pend_d;
  logic                    first_q, first_d;
  logic                    active_q, active_d;
  logic                    error_q, error_d;

  logic                    is_sof;
  logic [PIXEL_WIDTH-1:0]  in_pix;
  logic                    start_frame;
  logic [PIXEL_WIDTH-1:0]  start_pix;
  int                      fill_i, pcnt_i;

  assign is_sof = fifo_data[PIXEL_WIDTH];
  assign in_pix = fifo_data[PIXEL_WIDTH-1:0];
  assign rd_d   = fifo_rd_en;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    pcnt_d      = pcnt_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    addr_d      = addr_q;
    pix_d       = pix_q;
    sof_pend_d  = sof_pend_q;
    sof_pix_d   = sof_pix_q;
    done_pend_d = done_pend_q;
    first_d     = first_q;
    active_d    = active_q;
    error_d     = error_q;
    fifo_rd_en  = 1'b0;
    start_frame = 1'b0;
    start_pix   = in_pix;
    fill_i      = int'(fill_q);
    pcnt_i      = int'(pcnt_q);
    case (state_q)
      S_WAIT_INIT: if (init_done) state_d = S_HUNT;
      S_HUNT: begin
        fifo_rd_en = !fifo_empty;
        if (rd_q) begin
          if (is_sof) start_frame = 1'b1;
          else        error_d     = 1'b1;
        end
      end
      S_FILL: begin
        // Count the word still in flight so the buffer and frame never overrun,
        // and hold off the read behind an SOF that forces a flush.
        fifo_rd_en = !fifo_empty && (fill_i + int'(rd_q) < BP)
                     && (pcnt_i + int'(rd_q) < FRAME_PIXELS)
                     && !(rd_q && is_sof && fill_q != '0);
        if (rd_q) begin
          if (is_sof && fill_q != '0) begin
            sof_pend_d = 1'b1;
            sof_pix_d  = in_pix;
            state_d    = S_BURST;
          end else if (is_sof) begin
            start_frame = 1'b1;
          end else begin
            pix_d[fill_i] = in_pix;
            fill_d        = FW'(fill_i + 1);
            pcnt_d        = CW'(pcnt_i + 1);
            if (pcnt_i + 1 == FRAME_PIXELS) begin
              done_pend_d = 1'b1;
              state_d     = S_BURST;
            end else if (fill_i + 1 == BP) begin
              state_d = S_BURST;
            end
          end
        end
      end
      S_BURST: begin
        if (beat_q == BW'(BURST_BEATS - 1)) begin
          beat_d  = '0;
          gap_d   = '0;
          fill_d  = '0;
          addr_d  = addr_q + ADDR_WIDTH'(BP);
          for (int i = 0; i < BP; i++) pix_d[i] = '0;
          state_d = S_GAP;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (sof_pend_q) begin
            sof_pend_d  = 1'b0;
            start_frame = 1'b1;
            start_pix   = sof_pix_q;
          end else if (done_pend_q) begin
            done_pend_d = 1'b0;
            state_d     = S_HUNT;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_WAIT_INIT;
    endcase
    // The SOF word is pixel 0 of the new frame; buffer is always empty here.
    if (start_frame) begin
      first_d  = 1'b0;
      active_d = first_q ? active_q : !active_q;
      addr_d   = active_d ? FRAME_BASE_1 : FRAME_BASE_0;
      pix_d[0] = start_pix;
      fill_d   = FW'(1);
      pcnt_d   = CW'(1);
      state_d  = S_FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT_INIT;
      rd_q        <= 1'b0;
      fill_q      <= '0;
      pcnt_q      <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      addr_q      <= FRAME_BASE_0;
      for (int i = 0; i < BP; i++) pix_q[i] <= '0;
      sof_pend_q  <= 1'b0;
      sof_pix_q   <= '0;
      done_pend_q <= 1'b0;
      first_q     <= 1'b1;
      active_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      fill_q      <= fill_d;
      pcnt_q      <= pcnt_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      addr_q      <= addr_d;
      pix_q       <= pix_d;
      sof_pend_q  <= sof_pend_d;
      sof_pix_q   <= sof_pix_d;
      done_pend_q <= done_pend_d;
      first_q     <= first_d;
      active_q    <= active_d;
      error_q     <= error_d;
    end
  end

  assign cmd           = (state_q == S_BURST);
  assign cmd_en        = (state_q == S_BURST) && (beat_q == '0);
  assign addr          = (state_q == S_BURST) ? addr_q : '0;
  assign frame_done    = (state_q == S_BURST) && (beat_q == BW'(BURST_BEATS - 1)) && done_pend_q;
  assign active_buffer = active_q;
  assign error         = error_q;

  always_comb begin
    wr_data = '0;
    if (state_q == S_BURST)
      for (int l = 0; l < PPW; l++)
        wr_data[l*PIXEL_WIDTH +: PIXEL_WIDTH] = pix_q[int'(beat_q)*PPW + l];
  end

`ifdef FRAME_WRITE_PACKER_MASK_EN
  always_comb begin
    data_mask = '0;
    if (state_q == S_BURST)
      for (int b = 0; b < MW; b++)
        if (int'(beat_q)*PPW + (b*8)/PIXEL_WIDTH >= int'(fill_q)) data_mask[b] = 1'b1;
  end
`else
  assign data_mask = '0;
`endif

endmodule

// File: tb/tb_frame_write_packer.sv
// tb/tb_frame_write_packer.sv - self-checking bench for frame_write_packer
`timescale 1ns/1ps
module tb_frame_write_packer;
  localparam int PW = 16, MDW = 32, AW = 21, BB = 8, BP = 16, GAP = 11;
  localparam logic [AW-1:0] BASE0 = 21'h096040, BASE1 = 21'h12C080;

  logic clk = 1'b0, rst_n = 1'b0, init_done = 1'b0;
  always #5 clk = ~clk;

  logic sel = 1'b0, stall_en = 1'b0, fifo_empty = 1'b1;
  logic [PW:0] fifo_data = '0;
  logic [PW:0] fq[$];

  logic a_rd, a_cmd, a_cmd_en, a_act, a_done, a_err, a_empty;
  logic b_rd, b_cmd, b_cmd_en, b_act, b_done, b_err, b_empty;
  logic [AW-1:0] a_addr, b_addr, o_addr;
  logic [MDW-1:0] a_wd, b_wd, o_wd;
  logic [3:0] a_mask, b_mask, o_mask;
  logic o_rd, o_cmd, o_cmd_en, o_act, o_done, o_err;

  assign a_empty  = sel ? 1'b1 : fifo_empty;
  assign b_empty  = sel ? fifo_empty : 1'b1;
  assign o_rd     = sel ? b_rd : a_rd;
  assign o_cmd    = sel ? b_cmd : a_cmd;
  assign o_cmd_en = sel ? b_cmd_en : a_cmd_en;
  assign o_addr   = sel ? b_addr : a_addr;
  assign o_wd     = sel ? b_wd : a_wd;
  assign o_mask   = sel ? b_mask : a_mask;
  assign o_act    = sel ? b_act : a_act;
  assign o_done   = sel ? b_done : a_done;
  assign o_err    = sel ? b_err : a_err;

  frame_write_packer u_dut_a (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .fifo_empty(a_empty), .fifo_data(fifo_data),
    .fifo_rd_en(a_rd), .cmd(a_cmd), .cmd_en(a_cmd_en), .addr(a_addr), .wr_data(a_wd),
    .data_mask(a_mask), .active_buffer(a_act), .frame_done(a_done), .error(a_err));

  frame_write_packer #(.FRAME_PIXELS(20)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .fifo_empty(b_empty), .fifo_data(fifo_data),
    .fifo_rd_en(b_rd), .cmd(b_cmd), .cmd_en(b_cmd_en), .addr(b_addr), .wr_data(b_wd),
    .data_mask(b_mask), .active_buffer(b_act), .frame_done(b_done), .error(b_err));

  // FIFO model: Q valid the cycle after rd_en
  always @(posedge clk) if (o_rd && fq.size() > 0) fifo_data <= fq.pop_front();
  always @(negedge clk) fifo_empty = (fq.size() == 0) || (stall_en && $urandom_range(0, 2) == 0);

  int n_checks = 0, n_fail = 0;
  function automatic void chk(bit ok, string nm, logic [255:0] got, logic [255:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  // Reference model: whole-stream view of frames and bursts
  typedef struct { logic [AW-1:0] addr; logic [255:0] data; logic [31:0] mask; bit done; } burst_t;
  burst_t exp_q[$];
  logic [PW-1:0] cur[$];
  int m_fp, m_cnt;
  bit m_in, m_seen, m_act, m_err;
  logic [AW-1:0] m_addr;

  function automatic void m_reset(int fp);
    exp_q.delete(); cur.delete();
    m_fp = fp; m_cnt = 0; m_in = 0; m_seen = 0; m_act = 0; m_err = 0; m_addr = BASE0;
  endfunction

  function automatic void m_emit(bit done);
    burst_t b;
    b.addr = m_addr; b.data = '0; b.mask = '0; b.done = done;
    for (int i = 0; i < BP; i++)
      if (i < cur.size()) b.data[i*16 +: 16] = cur[i];
      else b.mask[i*2 +: 2] = 2'b11;
`ifndef FRAME_WRITE_PACKER_MASK_EN
    b.mask = '0;
`endif
    exp_q.push_back(b);
    cur.delete();
    m_addr = m_addr + AW'(BP);
  endfunction

  function automatic void m_add(logic [PW-1:0] p);
    cur.push_back(p);
    m_cnt++;
    if (m_cnt == m_fp) begin m_emit(1); m_in = 0; end
    else if (cur.size() == BP) m_emit(0);
  endfunction

  function automatic void m_word(bit sof, logic [PW-1:0] p);
    if (sof) begin
      if (m_in && cur.size() > 0) m_emit(0);
      if (m_seen) m_act = !m_act;
      m_seen = 1; m_addr = m_act ? BASE1 : BASE0; m_cnt = 0; m_in = 1;
      m_add(p);
    end else if (m_in) m_add(p);
    else m_err = 1;
  endfunction

  task automatic push_frame(int pre, int n);
    logic [PW-1:0] p;
    for (int i = 0; i < pre + n; i++) begin
      p = 16'($urandom);
      fq.push_back({(i == pre), p});
      m_word(i == pre, p);
    end
  endtask

  // Burst monitor / scoreboard
  int cyc = 0, last_end = -1000, mon_beat = 0, mon_bursts = 0, done_cnt = 0;
  bit mon_act = 0, shape_ok, got_done, done_bad;
  logic [AW-1:0] got_addr;
  logic [255:0] got_data;
  logic [31:0] got_mask;
  burst_t mon_e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mon_act = 0; last_end = -1000;
    end else begin
      if (o_done) done_cnt++;
      if (!mon_act && o_cmd_en) begin
        if (last_end >= 0) chk(cyc - last_end - 1 >= GAP, "cmd_gap", cyc - last_end - 1, GAP);
        mon_act = 1; mon_beat = 0; got_addr = o_addr; shape_ok = o_cmd;
        got_data = '0; got_mask = '0; got_done = 0; done_bad = 0;
      end
      if (mon_act) begin
        if (mon_beat > 0 && (o_cmd_en || !o_cmd || o_addr != got_addr)) shape_ok = 0;
        got_data[mon_beat*32 +: 32] = o_wd;
        got_mask[mon_beat*4 +: 4] = o_mask;
        if (o_done) begin if (mon_beat == BB - 1) got_done = 1; else done_bad = 1; end
        if (mon_beat == BB - 1) begin
          if (exp_q.size() == 0) chk(0, "unexpected_burst", got_addr, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk(got_addr == mon_e.addr, "burst_addr", got_addr, mon_e.addr);
            chk(got_data == mon_e.data, "burst_data", got_data, mon_e.data);
            chk(got_mask == mon_e.mask, "burst_mask", got_mask, mon_e.mask);
            chk(got_done == mon_e.done && !done_bad, "burst_frame_done", got_done, mon_e.done);
            chk(shape_ok, "burst_shape", shape_ok, 1);
          end
          mon_act = 0; last_end = cyc; mon_bursts++;
        end
        mon_beat++;
      end
    end
  end

  task automatic do_reset(int fp);
    @(posedge clk); #2;
    rst_n = 0; init_done = 0; fq.delete();
    #1;
    chk({o_rd, o_cmd, o_cmd_en, o_addr, o_wd, o_mask, o_act, o_done, o_err} == '0, "reset_outputs",
        {o_rd, o_cmd, o_cmd_en, o_addr, o_wd, o_mask, o_act, o_done, o_err}, 0);
    m_reset(fp);
    repeat (3) @(posedge clk); #2 rst_n = 1;
    repeat (2) @(posedge clk); #2 init_done = 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int idle = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (fq.size() == 0 && !mon_act && !o_rd) idle++; else idle = 0;
      if (idle >= 40) return;
    end
    chk(0, "idle_timeout", fq.size(), 0);
  endtask

  typedef struct { int pre; int npix; int ntail; bit dut_b; int exp_bursts; bit exp_err; bit exp_act; int exp_done; } row_t;
  row_t rows[5];

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int b0, d0, k;
    bit found;
    rows[0] = '{0, 16, 0,  0, 1, 0, 0, 0};
    rows[1] = '{0, 32, 0,  0, 2, 0, 0, 0};
    rows[2] = '{0, 21, 16, 0, 3, 0, 1, 0};
    rows[3] = '{5, 16, 0,  0, 1, 1, 0, 0};
    rows[4] = '{0, 24, 0,  1, 2, 1, 0, 1};
    m_reset(307200);

    for (int r = 0; r < 5; r++) begin
      sel = rows[r].dut_b;
      stall_en = (r % 2 == 1);
      do_reset(rows[r].dut_b ? 20 : 307200);
      b0 = mon_bursts; d0 = done_cnt;
      push_frame(rows[r].pre, rows[r].npix);
      if (rows[r].ntail > 0) push_frame(0, rows[r].ntail);
      wait_idle();
      chk(mon_bursts - b0 == rows[r].exp_bursts, $sformatf("row%0d_bursts", r), mon_bursts - b0, rows[r].exp_bursts);
      chk(o_err == rows[r].exp_err, $sformatf("row%0d_error", r), o_err, rows[r].exp_err);
      chk(o_act == rows[r].exp_act, $sformatf("row%0d_active", r), o_act, rows[r].exp_act);
      chk(done_cnt - d0 == rows[r].exp_done, $sformatf("row%0d_frame_done", r), done_cnt - d0, rows[r].exp_done);
      chk(exp_q.size() == 0, $sformatf("row%0d_sb_drained", r), exp_q.size(), 0);
    end
    sel = 0;

    // reset asserted during beat 3 of a burst
    stall_en = 0;
    do_reset(307200);
    push_frame(0, 16);
    found = 0;
    for (k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      if (o_cmd_en) found = 1;
    end
    chk(found, "midrst_cmd_en_seen", found, 1);
    repeat (3) @(posedge clk); #2;
    chk(o_cmd == 1'b1, "midrst_beat3_cmd", o_cmd, 1);
    rst_n = 0;
    #1;
    chk(o_cmd_en == 0 && o_cmd == 0 && o_wd == '0, "midrst_async_clear", {o_cmd_en, o_cmd, o_wd}, 0);
    fq.delete(); m_reset(307200);
    repeat (2) @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    push_frame(0, 16);
    wait_idle();
    chk(exp_q.size() == 0, "midrst_resume_drained", exp_q.size(), 0);

    // random multi-frame stream with stalls
    do_reset(307200);
    stall_en = 1;
    for (int f = 0; f < 4; f++) push_frame($urandom_range(0, 2), $urandom_range(1, 40));
    wait_idle();
    chk(exp_q.size() == 0, "rand_sb_drained", exp_q.size(), 0);
    chk(o_err == m_err, "rand_error", o_err, m_err);
    chk(o_act == m_act, "rand_active", o_act, m_act);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
